// File: rtl/cacheline_adapter_pkg.sv
// Shared types and widths for the cache-line to burst-memory adapter.
package cacheline_adapter_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int ADDR_W   = 32;

  // Clears the byte-offset-within-line bits so every burst starts on a line boundary.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_BURST,
    RESP
  } state_e;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts single-cycle 256-bit line requests from a cache into 4-beat
// 64-bit bursts on a burst memory port, and back again for reads.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,

  input  logic [ADDR_W-1:0]   ufp_addr,
  input  logic                ufp_read,
  input  logic                ufp_write,
  input  logic [LINE_W-1:0]   ufp_wdata,
  output logic [LINE_W-1:0]   ufp_rdata,
  output logic                ufp_resp,

  output logic [ADDR_W-1:0]   bmem_addr,
  output logic                bmem_read,
  output logic                bmem_write,
  output logic [BEAT_W-1:0]   bmem_wdata,
  input  logic                bmem_ready,
  input  logic [BEAT_W-1:0]   bmem_rdata,
  input  logic                bmem_rvalid
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  // Assembly buffer for read beats, or the captured line during a writeback.
  logic [LINE_W-1:0]  line_q,  line_d;
  // Last completed read line; kept apart so a writeback never disturbs it.
  logic [LINE_W-1:0]  rdata_q, rdata_d;

  logic [ADDR_W-1:0]  aligned_addr;

  assign aligned_addr = ufp_addr & ALIGN_MASK;
  assign ufp_rdata    = rdata_q;

  // Next-state, datapath updates and all strobe outputs.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave one unassigned, which would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    line_d     = line_q;
    rdata_d    = rdata_q;
    ufp_resp   = 1'b0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = addr_q;
    bmem_wdata = line_q[cnt_q*BEAT_W +: BEAT_W];

    unique case (state_q)
      IDLE: begin
        // Commands go straight out in the accepting cycle, so address and
        // first write beat come from the request, not the latched copies.
        bmem_addr  = aligned_addr;
        bmem_wdata = ufp_wdata[BEAT_W-1:0];
        if (bmem_ready) begin
          if (ufp_read) begin
            // Read wins when both requests are raised together.
            bmem_read = 1'b1;
            addr_d    = aligned_addr;
            cnt_d     = '0;
            state_d   = RD_WAIT;
          end else if (ufp_write) begin
            bmem_write = 1'b1;
            addr_d     = aligned_addr;
            line_d     = ufp_wdata;
            cnt_d      = CNT_W'(1);
            state_d    = WR_BURST;
          end
        end
      end

      RD_WAIT: begin
        if (bmem_rvalid) begin
          line_d[cnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            // Publish the full line so it is visible in the response cycle.
            rdata_d = line_d;
            state_d = RESP;
          end
        end
      end

      WR_BURST: begin
        // Beats 1..3 stream on consecutive cycles without waiting on memory.
        bmem_write = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BEATS - 1)) begin
          state_d = RESP;
        end
      end

      RESP: begin
        ufp_resp = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, beat counter, address and line registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the line buffers are reset because ufp_rdata must read as zero
      // until the first read completes; this costs reset fan-out on 512 flops.
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
